maze_walker: RTL

//  Parametrised wall-following maze solver; successor to the fixed 64x64 right-hand walker.

---
 rtl/maze_walker.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/maze_walker.sv
// Wall-following maze walker: steps from a start cell to the first border cell, marking its path.
// Latency: 3/5/7 cycles per move (side/front/other-or-back open), plus 1 cycle to mark the exit cell.
// Handshake: start is accepted only when not busy; done and timeout are held until the next start.
module maze_walker #(
  parameter int ADDR_W    = 6,
  parameter int STEP_W    = 16,
  parameter int MAX_STEPS = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] starting_row,
  input  logic [ADDR_W-1:0] starting_col,
  input  logic              follow_left,
  input  logic              maze_in,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              maze_oe,
  output logic              maze_we,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [STEP_W-1:0] steps
);

  typedef enum logic [3:0] {
    S_IDLE, S_PROBE_SIDE, S_EVAL_SIDE, S_PROBE_FWD, S_EVAL_FWD,
    S_PROBE_OTHER, S_EVAL_OTHER, S_MOVE, S_MARK_EXIT, S_DONE
  } state_t;

  localparam logic [1:0]        DIR_UP    = 2'd0;
  localparam logic [1:0]        DIR_RIGHT = 2'd1;
  localparam logic [1:0]        DIR_DOWN  = 2'd2;
  localparam logic [1:0]        DIR_LEFT  = 2'd3;
  localparam logic [ADDR_W-1:0] IDX_MAX   = '1;
  localparam logic [STEP_W-1:0] STEP_LIM  = STEP_W'(MAX_STEPS);

  state_t            state;
  logic [ADDR_W-1:0] pos_row, pos_col;
  logic [1:0]        dir;
  logic              hand;

  // Neighbour row/col of a cell in a given direction; wraps modulo the maze size.
  function automatic logic [ADDR_W-1:0] nbr_row(input logic [ADDR_W-1:0] r, input logic [1:0] d);
    if (d == DIR_UP)        return r - ADDR_W'(1);
    else if (d == DIR_DOWN) return r + ADDR_W'(1);
    else                    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] nbr_col(input logic [ADDR_W-1:0] c, input logic [1:0] d);
    if (d == DIR_RIGHT)     return c + ADDR_W'(1);
    else if (d == DIR_LEFT) return c - ADDR_W'(1);
    else                    return c;
  endfunction

  function automatic logic on_border(input logic [ADDR_W-1:0] r, input logic [ADDR_W-1:0] c);
    return (r == '0) || (r == IDX_MAX) || (c == '0) || (c == IDX_MAX);
  endfunction

  // Hand-relative directions for the current heading; "other" is the side opposite the hand.
  logic [1:0]        side_dir, other_dir, start_side;
  logic [ADDR_W-1:0] fwd_row, fwd_col;
  logic [STEP_W-1:0] steps_inc;

  assign side_dir   = hand ? (dir - 2'd1) : (dir + 2'd1);
  assign other_dir  = side_dir + 2'd2;
  assign start_side = follow_left ? DIR_LEFT : DIR_RIGHT;
  assign fwd_row    = nbr_row(pos_row, dir);
  assign fwd_col    = nbr_col(pos_col, dir);
  assign steps_inc  = steps + STEP_W'(1);

  // Walker FSM; every output is set on the transition into the state that presents it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pos_row <= '0;
      pos_col <= '0;
      dir     <= DIR_UP;
      hand    <= 1'b0;
      row     <= '0;
      col     <= '0;
      maze_oe <= 1'b0;
      maze_we <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      timeout <= 1'b0;
      steps   <= '0;
    end else begin
      maze_oe <= 1'b0;
      maze_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            pos_row <= starting_row;
            pos_col <= starting_col;
            hand    <= follow_left;
            dir     <= DIR_UP;
            steps   <= '0;
            done    <= 1'b0;
            timeout <= 1'b0;
            busy    <= 1'b1;
            if (on_border(starting_row, starting_col)) begin
              state   <= S_MARK_EXIT;
              maze_we <= 1'b1;
              row     <= starting_row;
              col     <= starting_col;
            end else begin
              state   <= S_PROBE_SIDE;
              maze_oe <= 1'b1;
              row     <= nbr_row(starting_row, start_side);
              col     <= nbr_col(starting_col, start_side);
            end
          end
        end
        S_PROBE_SIDE:  state <= S_EVAL_SIDE;
        S_PROBE_FWD:   state <= S_EVAL_FWD;
        S_PROBE_OTHER: state <= S_EVAL_OTHER;
        S_EVAL_SIDE: begin
          if (!maze_in) begin
            dir     <= side_dir;
            state   <= S_MOVE;
            maze_we <= 1'b1;
            row     <= pos_row;
            col     <= pos_col;
          end else begin
            state   <= S_PROBE_FWD;
            maze_oe <= 1'b1;
            row     <= fwd_row;
            col     <= fwd_col;
          end
        end
        S_EVAL_FWD: begin
          if (!maze_in) begin
            state   <= S_MOVE;
            maze_we <= 1'b1;
            row     <= pos_row;
            col     <= pos_col;
          end else begin
            state   <= S_PROBE_OTHER;
            maze_oe <= 1'b1;
            row     <= nbr_row(pos_row, other_dir);
            col     <= nbr_col(pos_col, other_dir);
          end
        end
        S_EVAL_OTHER: begin
          // All three probed sides walled: turn back without probing behind.
          dir     <= maze_in ? (dir + 2'd2) : other_dir;
          state   <= S_MOVE;
          maze_we <= 1'b1;
          row     <= pos_row;
          col     <= pos_col;
        end
        S_MOVE: begin
          pos_row <= fwd_row;
          pos_col <= fwd_col;
          steps   <= steps_inc;
          // Reaching the border wins over hitting the step limit on the same move.
          if (on_border(fwd_row, fwd_col)) begin
            state   <= S_MARK_EXIT;
            maze_we <= 1'b1;
            row     <= fwd_row;
            col     <= fwd_col;
          end else if (steps_inc == STEP_LIM) begin
            state   <= S_DONE;
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            state   <= S_PROBE_SIDE;
            maze_oe <= 1'b1;
            row     <= nbr_row(fwd_row, side_dir);
            col     <= nbr_col(fwd_col, side_dir);
          end
        end
        S_MARK_EXIT: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
